stream_mux_rr: RTL
==================

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter WIDTH, default 32: data bits per channel.
REQ-002 Parameter N, default 4: number of input channels, minimum 2.
REQ-003 Parameter SELW, default $clog2(N): width of select and channel-tag fields.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mode  input  1  0 = fixed select via sel; 1 = round-robin among valid channels.
REQ-007 sel  input  SELW  channel index used when mode=0.
REQ-008 in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  N  per-channel valid.
REQ-010 in_ready  output  N  per-channel ready; at most one bit high per cycle.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data/out_chan hold a word.
REQ-013 out_ready  input  1  downstream accepts the word when high with out_valid.
REQ-014 out_chan  output  SELW  index of the channel that supplied out_data.

Function
REQ-015 Single output register stage; load = !out_valid || out_ready, evaluated combinationally each cycle.
REQ-016 Mode 0: grant = sel when sel < N and in_valid[sel]=1; otherwise there is no grant. sel >= N never grants.
REQ-017 Mode 1: grant = first i with in_valid[i]=1, searching last+1, last+2, ... modulo N; "last" is the round-robin pointer.
REQ-018 in_ready[i] = load && (grant == i); in_ready is all-zero when load=0 or there is no grant.
REQ-019 On load with grant g: out_data <= channel g data, out_chan <= g, out_valid <= 1, all on the next edge; latency is exactly 1 cycle.
REQ-020 On load with no grant: out_valid <= 0; out_data and out_chan hold their values.
REQ-021 When load=0 (out_valid=1, out_ready=0), out_data, out_chan and out_valid hold, with no input consumed.
REQ-022 Pointer last <= g only on a mode-1 transfer; mode-0 transfers and idle cycles leave last unchanged.
REQ-023 Sustained throughput is one word per cycle when out_ready=1 and some eligible channel is valid.
REQ-024 Simultaneous output drain and input accept in one cycle is legal and replaces the word with no bubble.
REQ-025 Changes to mode or sel take effect on the grant of the same cycle and never alter an already-registered word.
REQ-026 Pointer wrap: after a grant to N-1, the search starts at 0.

Reset
REQ-027 When reset=1 at an edge: out_valid=0, out_data=0, out_chan=0, last=N-1, so the first mode-1 search starts at channel 0.
REQ-028 in_ready is forced to all-zero while reset=1.
REQ-029 A word held in the output register is discarded by reset, with no handshake completed.

Structure
REQ-030 A shared package/header mux_pkg holds MODE_FIXED=0, MODE_RR=1 and the clog2 helper; no other constants belong there.
REQ-031 The round-robin search is a combinational sub-module rr_arbiter (inputs: request vector, pointer; outputs: grant index, grant-found flag), parametrised by N.
REQ-032 The design is parametric, with no hard-coded 32 or 4; a competent implementation is 120-400 lines.

Verification
REQ-033 Mode 0, sel=2, in_valid=4'b0100, ch2 data=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100; on the next cycle out_valid=1, out_data=32'hDEADBEEF, out_chan=2.
REQ-034 Mode 1 after reset, in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0, one word per cycle.
REQ-035 Mode 1, in_valid=4'b1010, last=3 -> grants 1,3,1,3; after grant 3 the search wraps to 0 and picks 1.
REQ-036 Output stalled (out_valid=1, out_ready=0) for 3 cycles with in_valid=4'b1111 -> in_ready=0 and out_data stable; when out_ready rises, the next grant occurs in that same cycle.
REQ-037 Mode 0, sel=1, in_valid[1]=0, other channels valid -> no grant and in_ready=0; after a drain, out_valid=0 on the next cycle.
REQ-038 Reset asserted with out_valid=1, last=2 -> the following cycle shows out_valid=0, out_data=0, out_chan=0, and the next mode-1 grant with all channels valid is channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared mode encodings and the width helper for the stream mux slice.
package mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first requester after ptr, wrapping modulo N.
// Purely combinational; no backpressure of its own.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int N    = 4,
   parameter int SELW = clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] grant,
   output logic            found
);

   // Walk from farthest to nearest so the nearest requester after ptr wins.
   always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      found = 1'b0;
      for (int k = N; k >= 1; k--) begin
         idx = (int'(ptr) + k) % N;
         if (req[idx]) begin
            grant = SELW'(idx);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 stream mux (fixed select or round-robin) into one output register, 1-cycle latency.
// Accepts a word whenever the register is empty or draining; in_ready is all-zero while stalled.
module stream_mux_rr
   import mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SELW  = clog2(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mode,
   input  logic [SELW-1:0]    sel,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SELW-1:0]    out_chan
);

   logic            load;
   logic            fixed_vld;
   logic            rr_found;
   logic            grant_vld;
   logic [SELW-1:0] rr_grant;
   logic [SELW-1:0] grant_idx;
   logic [SELW-1:0] last;

   rr_arbiter #(
      .N    (N),
      .SELW (SELW)
   ) u_arb (
      .req   (in_valid),
      .ptr   (last),
      .grant (rr_grant),
      .found (rr_found)
   );

   // Out-of-range sel matches no channel, so it never grants.
   always_comb begin
      fixed_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (int'(sel) == i && in_valid[i]) fixed_vld = 1'b1;
      end
   end

   assign grant_vld = (mode == MODE_RR) ? rr_found : fixed_vld;
   assign grant_idx = (mode == MODE_RR) ? rr_grant : sel;
   assign load      = !out_valid || out_ready;

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         in_ready[i] = !reset && load && grant_vld && (int'(grant_idx) == i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         last      <= SELW'(N - 1);
      end else if (load) begin
         out_valid <= grant_vld;
         if (grant_vld) begin
            out_data <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_chan <= grant_idx;
            if (mode == MODE_RR) last <= grant_idx;
         end
      end
   end

endmodule
